trace_player: RTL and testbench
===============================

# trace_player

Parametrised stimulus replay engine. Holds up to DEPTH input vectors of WIDTH bits and, on command, drives them out one per clock cycle, reproducing a recorded input trace in hardware. It sits between a loader (host/debug port) and the primary inputs of the design under test. The fixed single-step, 3-bit, run-once replay is generalised here to arbitrary width and depth, with abort, error reporting and an optional loop mode.

## Interface
- WIDTH, 3, bits per trace vector
- DEPTH, 16, maximum number of stored vectors (≥2)
- IDLE_VAL, '0, value driven on out_data when not replaying
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  append wr_data to the trace
- wr_data  input  WIDTH  vector to append
- clear  input  1  discard trace and abort replay
- start  input  1  begin replay
- stop  input  1  end replay after the current vector
- out_data  output  WIDTH  replayed vector, IDLE_VAL otherwise
- out_valid  output  1  out_data is a trace entry
- busy  output  1  replay in progress
- done  output  1  one-cycle pulse on replay completion
- full  output  1  length == DEPTH
- len  output  $clog2(DEPTH+1)  stored vector count
- err  output  1  one-cycle pulse on rejected command

## Operation
- States: IDLE, PLAY, FINISH.
- IDLE: wr_en with !full stores at index len, len+1. wr_en with full → ignored, err.
- IDLE, start, post-write len>0 → PLAY; index=0. start with post-write len==0 → stays IDLE, err.
- Simultaneous wr_en and start in IDLE: write is accepted first; replay includes the new entry.
- PLAY: out_data=mem[index], out_valid=1, busy=1. Index advances every cycle.
- After index len-1 is presented → FINISH. stop in PLAY → FINISH next cycle; the vector current at the stop cycle is the last one presented.
- FINISH: out_valid=0, out_data=IDLE_VAL, done=1, busy=1 → IDLE.
- wr_en or start outside IDLE → ignored, err.
- clear has top priority in any state: len=0, index=0, → IDLE, no done pulse, out_data=IDLE_VAL next cycle. Stored data is not erased, only invalidated.
- Trace is retained after replay; repeated start replays it unchanged.
- Reset values: out_data=IDLE_VAL, out_valid=0, busy=0, done=0, full=0, len=0, err=0, state IDLE.

## Timing
- All outputs registered.
- start at edge N → first vector on out_data after edge N+1; vector k after edge N+1+k.
- done is high for the cycle after edge N+1+len.
- Back-to-back: start is accepted in IDLE the cycle after FINISH, so gap = 2 cycles between runs.
- stop at edge M in PLAY → out_valid low and done high after edge M+1.
- rst_n assertion takes effect immediately, mid-replay included; len returns to 0.
- Index wrap: index never exceeds len-1; DEPTH not a power of two must be handled without aliasing.

## Configuration
- TRACE_PLAYER_LOOP_EN defined: after index len-1, index wraps to 0 and PLAY continues; done only via stop or never; port loop_cnt (16 bits, saturating, reset 0, cleared on start) counts completed passes.
- Undefined: run-once behaviour as above; loop_cnt port absent.

## Structure
- Package trace_pkg: state enum (IDLE, PLAY, FINISH), length-width helper function.
- Sub-module trace_mem: DEPTH×WIDTH storage, synchronous write, registered read addressed by next index.
- FSM, counters and error logic in trace_player.

## Test plan
- Reset then load 3'b100, 3'b000; start → out_data 100 then 000 with out_valid, done pulse after, out_data back to IDLE_VAL.
- Load DEPTH=16 entries; 17th wr_en → err pulse, len stays 16, full=1; replay produces all 16 in order.
- start with len 0 → err pulse, busy stays 0; wr_en+start same cycle with len 0 → one-vector replay.
- stop on 2nd vector of 5 → exactly 2 vectors valid, done next cycle; clear on 3rd of 5 → no done, len 0.
- rst_n low during PLAY → all outputs at reset values immediately; start afterwards → err.
- With TRACE_PLAYER_LOOP_EN, 3 entries, run 10 cycles then stop → sequence wraps 0,1,2,0,…; loop_cnt=3 on completed passes.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the trace replay engine: FSM state encoding and the
// width helper for the stored-length counter.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Bits needed to hold a count of 0..depth inclusive.
  function automatic int len_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/trace_mem.sv
// DEPTH x WIDTH trace storage: synchronous write, registered read that
// returns IDLE_VAL whenever the read enable is low.
module trace_mem #(
  parameter int              WIDTH    = 3,
  parameter int              DEPTH    = 16,
  parameter logic [WIDTH-1:0] IDLE_VAL = '0,
  localparam int             IW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [IW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd_en,
  input  logic [IW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // A write and a replay start can land on the same entry in one cycle;
  // forward the incoming word so the first replayed vector is the new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_rdata <= IDLE_VAL;
    else if (!i_rd_en)                   r_rdata <= IDLE_VAL;
    else if (i_we && i_waddr == i_raddr) r_rdata <= i_wdata;
    else                                 r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/trace_player.sv
// Stimulus replay engine: records up to DEPTH vectors and plays them back one
// per cycle. Define TRACE_PLAYER_LOOP_EN for continuous looping with o_loop_cnt.
module trace_player
  import trace_pkg::*;
#(
  parameter int               WIDTH    = 3,
  parameter int               DEPTH    = 16,
  parameter logic [WIDTH-1:0] IDLE_VAL = '0,
  localparam int              LW       = len_width(DEPTH),
  localparam int              IW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic             i_stop,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_full,
`ifdef TRACE_PLAYER_LOOP_EN
  output logic [15:0]      o_loop_cnt,
`endif
  output logic [LW-1:0]    o_len,
  output logic             o_err
);

  state_t        r_state, w_state_next;
  logic [IW-1:0] r_idx, w_idx_next;
  logic [LW-1:0] r_len, w_len_next;
  logic          r_full, r_valid, r_busy, r_done, r_err;
  logic          w_err_next, w_wr_ok, w_last;
`ifdef TRACE_PLAYER_LOOP_EN
  logic          w_start_ok, w_wrap;
  logic [15:0]   r_loop_cnt;
`endif

  assign w_last = (LW'(r_idx) + LW'(1)) == r_len;

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_len_next   = r_len;
    w_err_next   = 1'b0;
    w_wr_ok      = 1'b0;
`ifdef TRACE_PLAYER_LOOP_EN
    w_start_ok   = 1'b0;
    w_wrap       = 1'b0;
`endif
    if (i_clear) begin
      w_state_next = ST_IDLE;
      w_idx_next   = '0;
      w_len_next   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_wr_en) begin
            if (r_full) begin
              w_err_next = 1'b1;
            end else begin
              w_wr_ok    = 1'b1;
              w_len_next = r_len + LW'(1);
            end
          end
          // Start looks at the post-write length so a same-cycle write is replayed.
          if (i_start) begin
            if (w_len_next != '0) begin
              w_state_next = ST_PLAY;
              w_idx_next   = '0;
`ifdef TRACE_PLAYER_LOOP_EN
              w_start_ok   = 1'b1;
`endif
            end else begin
              w_err_next = 1'b1;
            end
          end
        end
        ST_PLAY: begin
          w_err_next = i_wr_en | i_start;
          if (i_stop) begin
            w_state_next = ST_FINISH;
          end else if (w_last) begin
`ifdef TRACE_PLAYER_LOOP_EN
            w_idx_next = '0;
            w_wrap     = 1'b1;
`else
            w_state_next = ST_FINISH;
`endif
          end else begin
            w_idx_next = r_idx + IW'(1);
          end
        end
        default: begin
          w_err_next   = i_wr_en | i_start;
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_full  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_len   <= w_len_next;
      r_full  <= (w_len_next == LW'(DEPTH));
      r_valid <= (w_state_next == ST_PLAY);
      r_busy  <= (w_state_next != ST_IDLE);
      r_done  <= (w_state_next == ST_FINISH);
      r_err   <= w_err_next;
    end
  end

`ifdef TRACE_PLAYER_LOOP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_loop_cnt <= '0;
    else if (w_start_ok)              r_loop_cnt <= '0;
    else if (w_wrap && ~&r_loop_cnt)  r_loop_cnt <= r_loop_cnt + 16'd1;
  end
  assign o_loop_cnt = r_loop_cnt;
`endif

  trace_mem #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .IDLE_VAL (IDLE_VAL)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr_ok),
    .i_waddr (r_len[IW-1:0]),
    .i_wdata (i_wr_data),
    .i_rd_en (w_state_next == ST_PLAY),
    .i_raddr (w_idx_next),
    .o_rdata (o_out_data)
  );

  assign o_out_valid = r_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_full      = r_full;
  assign o_len       = r_len;
  assign o_err       = r_err;

endmodule

// File: tb/tb_trace_player.sv
// Directed bench for trace_player (WIDTH=3, DEPTH=16, IDLE_VAL=0); the loop
// scenario is compiled in when TRACE_PLAYER_LOOP_EN is defined.
module tb_trace_player;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_data = '0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [2:0] out_data;
  logic       out_valid, busy, done, full, err;
  logic [4:0] len;
`ifdef TRACE_PLAYER_LOOP_EN
  logic [15:0] loop_cnt;
`endif

  int n_vec = 0;
  int n_miscmp = 0;

  always #5 clk = ~clk;

  trace_player dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (wr_en),
    .i_wr_data   (wr_data),
    .i_clear     (clear),
    .i_start     (start),
    .i_stop      (stop),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .o_busy      (busy),
    .o_done      (done),
    .o_full      (full),
`ifdef TRACE_PLAYER_LOOP_EN
    .o_loop_cnt  (loop_cnt),
`endif
    .o_len       (len),
    .o_err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] v);
    wr_en = 1'b1;
    wr_data = v;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  function automatic logic [2:0] pat(input int i);
    return 3'((i * 3 + 1) % 8);
  endfunction

  initial begin
    // Reset values
    #3;
    check("rst out_data", 32'(out_data), 0);
    check("rst out_valid", 32'(out_valid), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst full", 32'(full), 0);
    check("rst len", 32'(len), 0);
    check("rst err", 32'(err), 0);
    rst_n = 1'b1;
    step();

    // Two-entry replay: 100 then 000
    wr(3'b100);
    check("t1 len1", 32'(len), 1);
    wr(3'b000);
    check("t1 len2", 32'(len), 2);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1 v0 data", 32'(out_data), 4);
    check("t1 v0 valid", 32'(out_valid), 1);
    check("t1 v0 busy", 32'(busy), 1);
    step();
    check("t1 v1 data", 32'(out_data), 0);
    check("t1 v1 valid", 32'(out_valid), 1);
    check("t1 v1 done", 32'(done), 0);
    step();
    check("t1 fin valid", 32'(out_valid), 0);
    check("t1 fin done", 32'(done), 1);
    check("t1 fin busy", 32'(busy), 1);
    check("t1 fin data", 32'(out_data), 0);
    step();
    check("t1 idle done", 32'(done), 0);
    check("t1 idle busy", 32'(busy), 0);

    // Fill to DEPTH, overflow write, full replay
    do_clear();
    check("t2 clr len", 32'(len), 0);
    for (int i = 0; i < 16; i++) wr(pat(i));
    check("t2 len16", 32'(len), 16);
    check("t2 full", 32'(full), 1);
    wr(3'b111);
    check("t2 ovf err", 32'(err), 1);
    check("t2 ovf len", 32'(len), 16);
    check("t2 ovf full", 32'(full), 1);
    step();
    check("t2 err clr", 32'(err), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t2 v%0d data", i), 32'(out_data), 32'(pat(i)));
      check($sformatf("t2 v%0d valid", i), 32'(out_valid), 1);
      step();
    end
    check("t2 done", 32'(done), 1);
    check("t2 end valid", 32'(out_valid), 0);
    step();

    // Start with empty trace, then write+start together
    do_clear();
    start = 1'b1;
    step();
    start = 1'b0;
    check("t3 empty err", 32'(err), 1);
    check("t3 empty busy", 32'(busy), 0);
    wr_en = 1'b1;
    wr_data = 3'b101;
    start = 1'b1;
    step();
    wr_en = 1'b0;
    start = 1'b0;
    check("t3 ws data", 32'(out_data), 5);
    check("t3 ws valid", 32'(out_valid), 1);
    check("t3 ws len", 32'(len), 1);
    check("t3 ws err", 32'(err), 0);
    step();
    check("t3 ws done", 32'(done), 1);
    check("t3 ws end valid", 32'(out_valid), 0);
    step();

    // Stop on the 2nd of 5 vectors
    do_clear();
    for (int i = 1; i <= 5; i++) wr(3'(i));
    start = 1'b1;
    step();
    start = 1'b0;
    check("t4 v0 data", 32'(out_data), 1);
    step();
    check("t4 v1 data", 32'(out_data), 2);
    check("t4 v1 valid", 32'(out_valid), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t4 stop valid", 32'(out_valid), 0);
    check("t4 stop done", 32'(done), 1);
    step();
    check("t4 idle busy", 32'(busy), 0);

    // Retained trace replays unchanged; clear on the 3rd vector
    start = 1'b1;
    step();
    start = 1'b0;
    check("t5 v0 data", 32'(out_data), 1);
    step();
    check("t5 v1 data", 32'(out_data), 2);
    step();
    check("t5 v2 data", 32'(out_data), 3);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t5 clr valid", 32'(out_valid), 0);
    check("t5 clr done", 32'(done), 0);
    check("t5 clr busy", 32'(busy), 0);
    check("t5 clr len", 32'(len), 0);
    check("t5 clr data", 32'(out_data), 0);
    step();
    check("t5 clr done2", 32'(done), 0);

    // Asynchronous reset mid-replay
    wr(3'b110);
    wr(3'b011);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t6 play data", 32'(out_data), 6);
    #2 rst_n = 1'b0;
    #1;
    check("t6 rst data", 32'(out_data), 0);
    check("t6 rst valid", 32'(out_valid), 0);
    check("t6 rst busy", 32'(busy), 0);
    check("t6 rst len", 32'(len), 0);
    #1 rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t6 start err", 32'(err), 1);
    check("t6 start busy", 32'(busy), 0);

`ifdef TRACE_PLAYER_LOOP_EN
    // Looping replay of 3 entries for 10 cycles, then stop
    begin
      logic [2:0] lv [3];
      lv[0] = 3'd6; lv[1] = 3'd1; lv[2] = 3'd3;
      do_clear();
      for (int i = 0; i < 3; i++) wr(lv[i]);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
        check($sformatf("t7 v%0d data", i), 32'(out_data), 32'(lv[i % 3]));
        check($sformatf("t7 v%0d valid", i), 32'(out_valid), 1);
        if (i < 9) step();
      end
      check("t7 loop_cnt", 32'(loop_cnt), 3);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("t7 stop done", 32'(done), 1);
      check("t7 stop valid", 32'(out_valid), 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
